// File: rtl/fp_to_linear.sv
// fp_to_linear: iterative converter from the 8-bit float format {S, E[2:0], F[3:0]}
// to a 12-bit two's-complement linear value D = (S ? -1 : 1) * F * 2^E.
// The significand is shifted left one bit per clock, so latency is E+3 cycles.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  input handshake; S/E/F are taken only in IDLE
//   S, E, F            sign (1 = negative), exponent, unsigned significand
//   out_valid/out_ready output handshake; D is held while out_valid is high
//   D                  two's-complement result, holds its last value outside DONE
//   busy               high whenever a conversion is in flight
module fp_to_linear #(
  parameter int E_W = 3,
  parameter int F_W = 4,
  localparam int D_W = F_W + (1 << E_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           S,
  input  logic [E_W-1:0] E,
  input  logic [F_W-1:0] F,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] D,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [D_W-1:0] acc;
  logic [D_W-1:0] acc_signed;
  logic [E_W-1:0] cnt;
  logic           sign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt == '0) state_d = SIGN;
      end
      SIGN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Negation wraps mod 2^D_W; F=0 yields 0 either way, so no negative zero.
  always_comb begin
    acc_signed = sign_q ? (~acc + D_W'(1)) : acc;
  end

  // D is a separate register loaded once per conversion so it stays stable
  // while acc is being shifted for the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      D      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= S;
            cnt    <= E;
            acc    <= D_W'(F);
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            acc <= acc << 1;
            cnt <= cnt - E_W'(1);
          end
        end
        SIGN: begin
          acc <= acc_signed;
          D   <= acc_signed;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_linear.sv
module tb_fp_to_linear;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        S = 1'b0;
  logic [2:0]  E = '0;
  logic [3:0]  F = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] D;
  logic        busy;

  fp_to_linear #(.E_W(3), .F_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .F(F),
    .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    int unsigned acc_n;
    int unsigned lat;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned ncount  = 0;
  int unsigned n_xfer  = 0;
  int unsigned rmode   = 0;  // 0: ready high, 1: random, 2: held low
  logic        prev_ov = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
    int m;
    m = int'(f) << e;
    if (s) m = -m;
    return m[11:0];
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor: checks value and latency at out_valid rise, value again at transfer.
  always @(negedge clk) begin
    ncount++;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          chk("ov_no_pending", 32'(q.size()), 32'd1);
        end else begin
          chk("d_rise", D, q[0].d);
          chk("latency", ncount - q[0].acc_n, q[0].lat);
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        chk("d_xfer", D, q[0].d);
        void'(q.pop_front());
        n_xfer++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f);
    bit ok;
    exp_t x;
    ok = 1'b0;
    @(negedge clk);
    S = s; E = e; F = f; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_wait", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      x.d = model(s, e, f);
      x.acc_n = ncount;
      x.lat = 32'(e) + 3;
      q.push_back(x);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int unsigned x0;
    bit spurious;

    // Reset values
    @(negedge clk);
    chk("rst_d", D, 12'h000);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 13*8 = 104, one-cycle pulse then back to IDLE
    send(1'b0, 3'd3, 4'b1101);
    @(negedge clk);
    chk("busy_shift", busy, 1'b1);
    chk("in_ready_shift", in_ready, 1'b0);
    wait_ov("ov_t1");
    chk("d_t1", D, 12'h068);
    @(negedge clk);
    chk("pulse_t1", out_valid, 1'b0);
    chk("in_ready_after", in_ready, 1'b1);

    send(1'b1, 3'd5, 4'b1101);
    wait_drain();
    send(1'b1, 3'd7, 4'b1111);
    wait_drain();
    send(1'b1, 3'd0, 4'b0000);
    wait_drain();
    send(1'b0, 3'd7, 4'b0000);
    wait_drain();

    // Backpressure: hold out_ready low in DONE with a second request pending
    rmode = 2;
    send(1'b0, 3'd2, 4'd5);
    wait_ov("ov_bp");
    S = 1'b1; E = 3'd1; F = 4'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_d", D, 12'd20);
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    x0 = n_xfer;
    rmode = 0;
    send(1'b1, 3'd1, 4'd3);
    chk("bp_one_xfer", n_xfer - x0, 32'd1);
    wait_drain();
    chk("bp_two_xfer", n_xfer - x0, 32'd2);

    // Reset during SHIFT of an E=6 conversion
    send(1'b0, 3'd6, 4'd9);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_d", D, 12'h000);
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    chk("no_spurious_ov", 32'(spurious), 32'd0);

    // Exhaustive sweep with random backpressure
    rmode = 1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] code;
      code = 8'(i);
      send(code[7], code[6:4], code[3:0]);
    end
    wait_drain();
    rmode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_to_linear.md
Name: fp_to_linear

Overview:
Iterative converter from the team's 8-bit floating-point format (sign S, 3-bit exponent E, 4-bit significand F) back to a 12-bit two's-complement linear value D = (S ? -1 : 1) * F * 2^E.
It is the inverse of the linear-to-float converter and sits on its output side. It is used for round-trip checking and for driving linear-domain consumers (seven-segment and LED display paths).
The block shifts one bit per clock, so latency depends on E. Both input and output use valid/ready handshakes.

Parameters:
E_W, 3, exponent width; output width is F_W + 2^E_W (12 at defaults). Only the defaults are required to be supported.
F_W, 4, significand width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  S/E/F are valid this cycle
in_ready  output  1  block can accept a conversion (high only in IDLE)
S  input  1  sign, 1 = negative
E  input  3  exponent
F  input  4  significand (unsigned magnitude, no hidden bit)
out_valid  output  1  D is valid, held until taken
out_ready  input  1  consumer accepts D
D  output  12  two's-complement result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; D=0; out_valid=0; in_ready=1; busy=0.
  - Internal accumulator, counter and sign latch are cleared.
- State machine: IDLE -> SHIFT -> SIGN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch sign=S, cnt=E, acc={8'b0,F}; go to SHIFT.
- SHIFT (one edge per iteration):
  - If cnt!=0: acc<=acc<<1 and cnt<=cnt-1.
  - If cnt==0: go to SIGN with no shift.
  - An input with E=n therefore spends n+1 cycles in SHIFT.
- SIGN (one cycle):
  - acc <= sign ? (~acc + 1) : acc, computed mod 2^12.
  - Go to DONE.
- DONE:
  - out_valid=1; D=acc; D is stable while out_valid=1.
  - On out_ready=1 at an edge: go to IDLE.
  - out_valid and D may change only after that edge.
- Latency: out_valid is first high E+3 cycles after the accepting edge, i.e. 3 cycles at E=0 and 10 cycles at E=7.
- Throughput: one conversion in flight; in_ready=0 from the accepting edge until DONE is left. in_valid outside IDLE is ignored.
- Same cycle as out_ready in DONE: a new in_valid is not accepted. Acceptance occurs at the first edge in IDLE.
- Arithmetic:
  - Magnitude max is 15*2^7 = 1920 (0x780), so there is no overflow or saturation.
  - Negative results span -1920..-1.
  - F=0 gives D=0 regardless of S and E; negative zero is never produced.
- D holds its last value while not in DONE. Only out_valid qualifies it.
- Reset mid-operation: immediate abort to reset values. The partially converted value is discarded and no out_valid pulse is emitted.
- rst deassertion is synchronous to clk by the system; the block adds no synchronizer.

Test Plan:
- S=0,E=3,F=4'b1101 accepted, out_ready=1 -> out_valid on the 6th cycle after accept, D=12'h068 (104), one-cycle pulse, in_ready high next cycle.
- S=1,E=5,F=4'b1101 -> D=12'hE60 (-416) after 8 cycles; S=1,E=7,F=4'b1111 -> D=12'h880 (-1920) after 10 cycles.
- S=1,E=0,F=0 -> D=12'h000 after 3 cycles; S=0,E=7,F=0 -> D=12'h000.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and D held constant, in_ready=0, a second in_valid ignored. Raise out_ready -> exactly one transfer, then the second request is accepted.
- Assert rst during SHIFT of an E=6 conversion -> D=0, out_valid=0, in_ready=1 immediately, with no spurious out_valid after release.
- Exhaustive sweep of all 256 {S,E,F} codes with a random out_ready pattern -> each D equals the reference formula and the latency equals E+3.
